// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit path
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int TICK_W     = 4;
    localparam int DATA_W     = 8;

endpackage

// File: rtl/uart_tx_bitclk.sv
// uart_tx_bitclk: counts oversampled baud ticks and flags the last tick of each bit
module uart_tx_bitclk
    import uart_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tick_i,
    input  logic clr_i,
    output logic bit_end_o
);

    logic [TICK_W-1:0] cnt_q, cnt_d;

    // Clear wins over tick; the counter wraps naturally at the end of a bit
    always_comb cnt_d = clr_i ? '0 : tick_i ? cnt_q + 1'b1 : cnt_q;

    // Tick counter register
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;

    assign bit_end_o = tick_i && !clr_i && cnt_q == TICK_W'(OVERSAMPLE - 1);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain: drains the TX FIFO one byte at a time and serialises it; parity via UART_TX_PARITY_EN
module uart_tx_fifo_drain
    import uart_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              BAUD_TICK,
    input  logic              BIT8,
    input  logic              PARITY_EN,
    input  logic              ODD_N_EVEN,
    input  logic              FIFO_EMPTY,
    input  logic [DATA_W-1:0] FIFO_DATA,
    output logic              FIFO_RDB,
    output logic              TX,
    output logic              TX_BUSY
);

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic              bit8_q, bit8_d;
    logic              active, bit_end, last_bit, par_bit;
    tx_state_e         after_data;

    assign active   = state_q inside {ST_START, ST_DATA, ST_PARITY, ST_STOP};
    assign last_bit = bit_cnt_q == (bit8_q ? 3'd7 : 3'd6);

    uart_tx_bitclk u_bitclk (
        .clk_i     (CLK),
        .rst_ni    (RESET),
        .tick_i    (BAUD_TICK && active),
        .clr_i     (state_q == ST_LOAD),
        .bit_end_o (bit_end)
    );

`ifdef UART_TX_PARITY_EN
    logic par_en_q, par_en_d, odd_q, odd_d, par_q, par_d;

    assign after_data = par_en_q ? ST_PARITY : ST_STOP;
    assign par_bit    = par_q ^ odd_q;

    // Latch the parity mode per frame and fold in each bit as it leaves
    always_comb begin
        par_en_d = state_q == ST_LOAD ? PARITY_EN : par_en_q;
        odd_d    = state_q == ST_LOAD ? ODD_N_EVEN : odd_q;
        par_d    = state_q == ST_LOAD ? 1'b0 :
                   (state_q == ST_DATA && bit_end) ? par_q ^ shift_q[0] : par_q;
    end

    // Parity state registers
    always_ff @(posedge CLK or negedge RESET)
        if (!RESET) begin
            par_en_q <= 1'b0;
            odd_q    <= 1'b0;
            par_q    <= 1'b0;
        end else begin
            par_en_q <= par_en_d;
            odd_q    <= odd_d;
            par_q    <= par_d;
        end
`else
    logic unused_cfg;

    assign unused_cfg = PARITY_EN ^ ODD_N_EVEN;
    assign after_data = ST_STOP;
    assign par_bit    = 1'b1;
`endif

    // State register
    always_ff @(posedge CLK or negedge RESET)
        if (!RESET) state_q <= ST_IDLE;
        else        state_q <= state_d;

    // Next-state logic; empty is only consulted where a new fetch is decided
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (!FIFO_EMPTY) state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_WAIT;
            ST_WAIT:   state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_START;
            ST_START:  if (bit_end) state_d = ST_DATA;
            ST_DATA:   if (bit_end && last_bit) state_d = after_data;
            ST_PARITY: if (bit_end) state_d = ST_STOP;
            ST_STOP:   if (bit_end) state_d = FIFO_EMPTY ? ST_IDLE : ST_FETCH;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Capture the byte and frame format in LOAD, shift right at each data bit end
    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        bit8_d    = bit8_q;
        if (state_q == ST_LOAD) begin
            shift_d   = FIFO_DATA;
            bit_cnt_d = '0;
            bit8_d    = BIT8;
        end else if (state_q == ST_DATA && bit_end) begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
        end
    end

    // Datapath registers
    always_ff @(posedge CLK or negedge RESET)
        if (!RESET) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            bit8_q    <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            bit8_q    <= bit8_d;
        end

    // Outputs decoded from state so reset forces the line idle immediately
    always_comb begin
        FIFO_RDB = state_q != ST_FETCH;
        TX_BUSY  = state_q != ST_IDLE;
        TX       = state_q == ST_START  ? 1'b0 :
                   state_q == ST_DATA   ? shift_q[0] :
                   state_q == ST_PARITY ? par_bit : 1'b1;
    end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// tb_uart_tx_fifo_drain: directed bench for uart_tx_fifo_drain; expectations follow UART_TX_PARITY_EN
module tb_uart_tx_fifo_drain;

    logic       CLK = 0, RESET = 0, BAUD_TICK = 0;
    logic       BIT8 = 1, PARITY_EN = 0, ODD_N_EVEN = 0, FIFO_EMPTY = 1;
    logic [7:0] FIFO_DATA = 0;
    logic       FIFO_RDB, TX, TX_BUSY;

    int n_tests = 0, n_fail = 0, strobes = 0, bad_strobes = 0;
    logic [7:0] q[$];
    logic [7:0] pend = 0;
    logic       rd_d1 = 0;

`ifdef UART_TX_PARITY_EN
    localparam int          NB_A3E  = 10;
    localparam logic [10:0] EXP_A3E = 11'h346;
    localparam int          NB_A3O  = 11;
    localparam logic [10:0] EXP_A3O = 11'h746;
`else
    localparam int          NB_A3E  = 9;
    localparam logic [10:0] EXP_A3E = 11'h146;
    localparam int          NB_A3O  = 10;
    localparam logic [10:0] EXP_A3O = 11'h346;
`endif

    uart_tx_fifo_drain dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .BAUD_TICK  (BAUD_TICK),
        .BIT8       (BIT8),
        .PARITY_EN  (PARITY_EN),
        .ODD_N_EVEN (ODD_N_EVEN),
        .FIFO_EMPTY (FIFO_EMPTY),
        .FIFO_DATA  (FIFO_DATA),
        .FIFO_RDB   (FIFO_RDB),
        .TX         (TX),
        .TX_BUSY    (TX_BUSY)
    );

    always #5 CLK = ~CLK;

    // FIFO model: pop on the strobe edge, registered data visible two cycles after the strobe
    always @(posedge CLK) begin
        if (rd_d1) FIFO_DATA <= pend;
        rd_d1 <= !FIFO_RDB;
        if (!FIFO_RDB) begin
            strobes <= strobes + 1;
            if (q.size() == 0) bad_strobes <= bad_strobes + 1;
            else pend <= q.pop_front();
        end
    end

    // Baud tick every 4 clocks and empty flag, both driven away from the active edge
    initial begin
        int div;
        div = 0;
        forever begin
            @(negedge CLK);
            div = (div + 1) % 4;
            BAUD_TICK = (div == 0);
            FIFO_EMPTY = (q.size() == 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        FIFO_EMPTY = 0;
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            while (!BAUD_TICK) @(posedge CLK);
        end
        @(negedge CLK);
    endtask

    task automatic frame(input string tag, input int nb, input logic [10:0] exp_bits, input bit last);
        int c, t;
        logic [10:0] obs;
        c = 0;
        while (FIFO_RDB !== 1'b0 && c < 100) begin
            @(negedge CLK);
            c++;
        end
        check({tag, " strobe"}, FIFO_RDB, 0);
        if (FIFO_RDB !== 1'b0) return;
        c = 0;
        while (TX !== 1'b0 && c < 10) begin
            @(negedge CLK);
            c++;
        end
        check({tag, " gap"}, c, 3);
        obs = '0;
        for (int i = 0; i < nb; i++) begin
            wait_ticks(i == 0 ? 8 : 16);
            obs[i] = TX;
        end
        check({tag, " bits"}, obs, exp_bits);
        t = 0;
        c = 0;
        while (FIFO_RDB !== 1'b0 && TX_BUSY !== 1'b0 && c < 100) begin
            @(posedge CLK);
            if (BAUD_TICK) t++;
            @(negedge CLK);
            c++;
        end
        check({tag, " stop ticks"}, t, 8);
        check({tag, " busy"}, TX_BUSY, last ? 0 : 1);
    endtask

    initial begin
        int bad, s0, c;
        repeat (3) @(negedge CLK);
        check("reset tx", TX, 1);
        check("reset rdb", FIFO_RDB, 1);
        check("reset busy", TX_BUSY, 0);
        RESET = 1;

        bad = 0;
        repeat (4000) begin
            @(negedge CLK);
            if (TX !== 1'b1 || FIFO_RDB !== 1'b1 || TX_BUSY !== 1'b0) bad++;
        end
        check("idle empty", bad, 0);

        BIT8 = 1; PARITY_EN = 0; ODD_N_EVEN = 0;
        s0 = strobes;
        push(8'h55);
        frame("b55", 10, 11'h2AA, 1);
        check("b55 strobes", strobes - s0, 1);

        BIT8 = 0; PARITY_EN = 1; ODD_N_EVEN = 0;
        push(8'hA3);
        frame("a3 7e1", NB_A3E, EXP_A3E, 1);

        BIT8 = 1; PARITY_EN = 1; ODD_N_EVEN = 1;
        push(8'hA3);
        fork
            begin
                repeat (40) @(negedge CLK);
                BIT8 = 0; PARITY_EN = 0; ODD_N_EVEN = 0;
            end
        join_none
        frame("a3 8o1 held", NB_A3O, EXP_A3O, 1);

        BIT8 = 1; PARITY_EN = 0; ODD_N_EVEN = 0;
        s0 = strobes;
        push(8'h55); push(8'h0F); push(8'h30);
        frame("q0 55", 10, 11'h2AA, 0);
        frame("q1 0f", 10, 11'h21E, 0);
        frame("q2 30", 10, 11'h260, 1);
        check("queue strobes", strobes - s0, 3);

        push(8'h00);
        c = 0;
        while (TX !== 1'b0 && c < 100) begin
            @(negedge CLK);
            c++;
        end
        check("rst frame start", TX, 0);
        wait_ticks(8 + 16 * 4);
        check("rst pre data", TX, 0);
        #1 RESET = 0;
        #1;
        check("rst async tx", TX, 1);
        check("rst async busy", TX_BUSY, 0);
        @(negedge CLK);
        RESET = 1;
        s0 = strobes;
        bad = 0;
        repeat (400) begin
            @(negedge CLK);
            if (TX !== 1'b1 || FIFO_RDB !== 1'b1) bad++;
        end
        check("post reset idle", bad, 0);
        check("post reset strobes", strobes - s0, 0);
        check("strobes while empty", bad_strobes, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
